mem_port_arbiter: RTL

Round-robin arbiter sharing one synchronous single-port memory between two requesters, for example two multiply/normalise engines that both read operands from and write results to the same memory. It holds ownership across bursts of consecutive requests, caps each burst at MAX_BURST beats when the other side is waiting, and routes the one-cycle-late read data back to the requester that issued the read. It sits between the engine controllers and the memory. It does not buffer requests: a requester presents a request and holds it until granted.

---
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the shared single-port memory port.
// The arbiter uses the slave view; the surrounding system (engines + memory) uses the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    // requester 0
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              rvalid0;

    // requester 1
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              rvalid1;

    // shared read return and memory port
    logic [DATA_W-1:0] rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output gnt0, rvalid0,
        output gnt1, rvalid1,
        output rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  gnt0, rvalid0,
        input  gnt1, rvalid1,
        input  rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port memory between two requesters,
// with burst ownership capped at MAX_BURST beats while the other side waits.
module mem_port_arbiter #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    localparam int               CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_pri;
    logic              w_pri_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_rvalid0;
    logic              r_rvalid1;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    // Grants come from registered ownership and the live request, so a dropped request costs one idle cycle.
    assign w_gnt0 = (r_state == OWN0) && bus.req0;
    assign w_gnt1 = (r_state == OWN1) && bus.req1;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_state_nxt = r_state;
        w_pri_nxt   = r_pri;
        w_cnt_nxt   = r_cnt;

        case (r_state)
            IDLE: begin
                if (bus.req0 && bus.req1) w_state_nxt = r_pri ? OWN1 : OWN0;
                else if (bus.req0)        w_state_nxt = OWN0;
                else if (bus.req1)        w_state_nxt = OWN1;
            end
            OWN0: begin
                if (!bus.req0)                          w_state_nxt = bus.req1 ? OWN1 : IDLE;
                else if (bus.req1 && r_cnt == CNT_LAST) w_state_nxt = OWN1;
            end
            OWN1: begin
                if (!bus.req1)                          w_state_nxt = bus.req0 ? OWN0 : IDLE;
                else if (bus.req0 && r_cnt == CNT_LAST) w_state_nxt = OWN0;
            end
            default: w_state_nxt = IDLE;
        endcase

        // Leaving an owner hands tie priority to the other side; entering from IDLE keeps it.
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
            if (r_state == OWN0)      w_pri_nxt = 1'b1;
            else if (r_state == OWN1) w_pri_nxt = 1'b0;
        end else if (w_gnt0 || w_gnt1) begin
            w_cnt_nxt = (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (w_gnt0) begin
            w_mem_we    = bus.we0;
            w_mem_addr  = bus.addr0;
            w_mem_wdata = bus.wdata0;
        end else if (w_gnt1) begin
            w_mem_we    = bus.we1;
            w_mem_addr  = bus.addr1;
            w_mem_wdata = bus.wdata1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pri     <= 1'b0;
            r_cnt     <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state   <= w_state_nxt;
            r_pri     <= w_pri_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rvalid0 <= w_gnt0 & ~bus.we0;
            r_rvalid1 <= w_gnt1 & ~bus.we1;
        end
    end

    assign bus.gnt0      = w_gnt0;
    assign bus.gnt1      = w_gnt1;
    assign bus.rvalid0   = r_rvalid0;
    assign bus.rvalid1   = r_rvalid1;
    assign bus.rdata     = bus.mem_rdata;
    assign bus.mem_en    = w_gnt0 | w_gnt1;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;

endmodule
